// File: rtl/btb_upd_arb_pkg.sv
// Shared fetch-side types for the BTB update path: the update record,
// branch-type encodings and the write-port arbiter state.
package btb_upd_arb_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_typ_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  pos;
    logic [1:0]  typ;
    logic [63:0] tar;
  } btb_upd_t;

  typedef enum logic {
    ARB_NORMAL   = 1'b0,
    ARB_FORCE_PD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/btb_upd_arb_fifo.sv
// Small synchronous FIFO of BTB update records with flush. The caller never
// pushes when full or pops when empty; flush wins over push/pop.
module btb_upd_fifo
  import btb_upd_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  btb_upd_t                 din,
  output btb_upd_t                 head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  btb_upd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  // Storage carries no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/btb_upd_arb.sv
// BTB write-port arbiter: resolve updates win, predecode hints are buffered
// and droppable, with a starvation guard. BTBARB_PERF_EN adds perf counters.
module btb_upd_arb
  import btb_upd_arb_pkg::*;
#(
  parameter int PD_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pd_we_i,
  input  logic [63:0] pd_pc_i,
  input  logic [2:0]  pd_pos_i,
  input  logic [1:0]  pd_typ_i,
  input  logic [63:0] pd_tar_i,
  output logic        pd_drop_o,
  input  logic        rs_valid_i,
  input  logic [63:0] rs_pc_i,
  input  logic [2:0]  rs_pos_i,
  input  logic [1:0]  rs_typ_i,
  input  logic [63:0] rs_tar_i,
  output logic        rs_ready_o,
  input  logic        flush_i,
  input  logic        btb_busy_i,
  output logic        btb_we_o,
  output logic [63:0] btb_pc_o,
  output logic [2:0]  btb_pos_o,
  output logic [1:0]  btb_typ_o,
  output logic [63:0] btb_tar_o
`ifdef BTBARB_PERF_EN
  ,
  output logic [31:0] pd_drop_cnt_o,
  output logic [31:0] rs_stall_cnt_o
`endif
);
  localparam int CW = $clog2(PD_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  btb_upd_t   pd_in, rs_in, fifo_head, out_q;
  logic [CW:0] pd_count;
  logic        pd_empty, pd_full, push, pop;
  logic        gnt_rs, gnt_pd, pd_win;
  arb_state_e  state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  assign pd_in = {pd_pc_i, pd_pos_i, pd_typ_i, pd_tar_i};
  assign rs_in = {rs_pc_i, rs_pos_i, rs_typ_i, rs_tar_i};

  // Full is judged on the registered count; a flush-cycle push is silently lost.
  assign push      = pd_we_i && !pd_full && !flush_i;
  assign pd_drop_o = pd_we_i &&  pd_full && !flush_i;

  btb_upd_fifo #(.DEPTH(PD_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (push),
    .pop   (pop),
    .flush (flush_i),
    .din   (pd_in),
    .head  (fifo_head),
    .count (pd_count),
    .empty (pd_empty),
    .full  (pd_full)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    gnt_rs     = 1'b0;
    gnt_pd     = 1'b0;
    rs_ready_o = 1'b0;
    unique case (state_q)
      ARB_NORMAL: begin
        if (!btb_busy_i) begin
          if (rs_valid_i) begin
            gnt_rs     = 1'b1;
            rs_ready_o = 1'b1;
            if (!pd_empty) starve_d = starve_q + SW'(1);
          end else if (!pd_empty) begin
            gnt_pd   = 1'b1;
            starve_d = '0;
          end
        end
        // A flush empties the FIFO, so nothing is left waiting to be starved.
        if (flush_i) starve_d = '0;
        if (starve_d == SW'(STARVE_MAX)) state_d = ARB_FORCE_PD;
      end
      ARB_FORCE_PD: begin
        if (pd_empty) begin
          state_d  = ARB_NORMAL;
          starve_d = '0;
        end else if (!btb_busy_i) begin
          gnt_pd   = 1'b1;
          starve_d = '0;
          state_d  = ARB_NORMAL;
        end
      end
      default: state_d = ARB_NORMAL;
    endcase
  end

  assign pd_win = gnt_pd && !flush_i;
  assign pop    = pd_win;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
      btb_we_o <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      btb_we_o <= gnt_rs || pd_win;
      if (gnt_rs)      out_q <= rs_in;
      else if (pd_win) out_q <= fifo_head;
    end
  end

  assign btb_pc_o  = out_q.pc;
  assign btb_pos_o = out_q.pos;
  assign btb_typ_o = out_q.typ;
  assign btb_tar_o = out_q.tar;

`ifdef BTBARB_PERF_EN
  // Saturating event counters; deliberately untouched by flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pd_drop_cnt_o  <= '0;
      rs_stall_cnt_o <= '0;
    end else begin
      if (pd_drop_o && pd_drop_cnt_o != '1)
        pd_drop_cnt_o <= pd_drop_cnt_o + 32'd1;
      if (rs_valid_i && !rs_ready_o && rs_stall_cnt_o != '1)
        rs_stall_cnt_o <= rs_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_upd_arb.sv
// Scoreboard bench for btb_upd_arb: directed stimulus queues expected BTB
// writes; an independent monitor pops and compares on every btb_we_o.
module tb_btb_upd_arb;
  import btb_upd_arb_pkg::*;

  logic        clk, rst_n;
  logic        pd_we, rs_valid, flush, busy;
  logic [63:0] pd_pc, pd_tar, rs_pc, rs_tar;
  logic [2:0]  pd_pos, rs_pos;
  logic [1:0]  pd_typ, rs_typ;
  logic        pd_drop, rs_ready, btb_we;
  logic [63:0] btb_pc, btb_tar;
  logic [2:0]  btb_pos;
  logic [1:0]  btb_typ;
`ifdef BTBARB_PERF_EN
  logic [31:0] pd_drop_cnt, rs_stall_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  btb_upd_t exp_q[$];

  btb_upd_arb #(.PD_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .pd_we_i(pd_we), .pd_pc_i(pd_pc), .pd_pos_i(pd_pos), .pd_typ_i(pd_typ),
    .pd_tar_i(pd_tar), .pd_drop_o(pd_drop),
    .rs_valid_i(rs_valid), .rs_pc_i(rs_pc), .rs_pos_i(rs_pos), .rs_typ_i(rs_typ),
    .rs_tar_i(rs_tar), .rs_ready_o(rs_ready),
    .flush_i(flush), .btb_busy_i(busy),
    .btb_we_o(btb_we), .btb_pc_o(btb_pc), .btb_pos_o(btb_pos),
    .btb_typ_o(btb_typ), .btb_tar_o(btb_tar)
`ifdef BTBARB_PERF_EN
    , .pd_drop_cnt_o(pd_drop_cnt), .rs_stall_cnt_o(rs_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic btb_upd_t mk(input logic [63:0] pc, input logic [2:0] pos,
                                  input logic [1:0] typ, input logic [63:0] tar);
    btb_upd_t u;
    u.pc = pc; u.pos = pos; u.typ = typ; u.tar = tar;
    return u;
  endfunction

  // Monitor: every write must match the head of the expected queue.
  initial begin
    btb_upd_t e;
    forever begin
      @(negedge clk);
      if (btb_we) begin
        if (exp_q.size() == 0) chk("spurious_write", btb_we, 0);
        else begin
          e = exp_q.pop_front();
          chk("btb_write", {btb_pc, btb_pos, btb_typ, btb_tar}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_pd(input btb_upd_t u);
    pd_pc = u.pc; pd_pos = u.pos; pd_typ = u.typ; pd_tar = u.tar;
  endtask

  task automatic set_rs(input btb_upd_t u);
    rs_pc = u.pc; rs_pos = u.pos; rs_typ = u.typ; rs_tar = u.tar;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin step(); n++; end
    step();
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    btb_upd_t u;
    rst_n = 1'b0; pd_we = 0; rs_valid = 0; flush = 0; busy = 0;
    set_pd('0); set_rs('0);
    step(); step();
    chk("rst_we", btb_we, 0);
    chk("rst_pc", btb_pc, 0);
    chk("rst_tar", btb_tar, 0);
    chk("rst_ready", rs_ready, 0);
    chk("rst_drop", pd_drop, 0);
    rst_n = 1'b1;
    step();

    // Single push: written two edges after the push cycle.
    u = mk(64'h1000, 3'd3, BR_JUMP, 64'h2000);
    set_pd(u); pd_we = 1; exp_q.push_back(u);
    step(); pd_we = 0;
    chk("pd_lat_early", btb_we, 0);
    step();
    chk("pd_latency", btb_we, 1);
    drain("drain_single", 4);

    // Resolve beats a buffered predecode entry.
    busy = 1; u = mk(64'h1100, 3'd1, BR_COND, 64'h1180); set_pd(u); pd_we = 1;
    step(); pd_we = 0; busy = 0;
    set_rs(mk(64'h5000, 3'd2, BR_CALL, 64'h5500)); rs_valid = 1;
    exp_q.push_back(mk(64'h5000, 3'd2, BR_CALL, 64'h5500));
    exp_q.push_back(u);
    #1 chk("rs_ready_prio", rs_ready, 1);
    step(); rs_valid = 0;
    drain("drain_prio", 6);

    // Starvation: 8 resolves, forced predecode, then resolves again.
    busy = 1; u = mk(64'h3300, 3'd7, BR_RET, 64'h3330); set_pd(u); pd_we = 1;
    step(); pd_we = 0; busy = 0; rs_valid = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(64'h6000 + i, 3'(i), BR_COND, 64'h7000 + i));
    exp_q.push_back(u);
    for (int i = 8; i < 10; i++) exp_q.push_back(mk(64'h6000 + i, 3'(i), BR_COND, 64'h7000 + i));
    for (int i = 0; i < 11; i++) begin
      int k;
      k = (i <= 8) ? i : i - 1;
      set_rs(mk(64'h6000 + k, 3'(k), BR_COND, 64'h7000 + k));
      #1 chk("rs_ready_starve", rs_ready, (i == 8) ? 0 : 1);
      step();
    end
    rs_valid = 0;
    drain("drain_starve", 6);

    // Overflow: fifth push while busy is dropped.
    busy = 1; pd_we = 1;
    for (int i = 0; i < 5; i++) begin
      u = mk(64'h4000 + 64'(i * 16), 3'(i), BR_JUMP, 64'h8000 + i);
      set_pd(u);
      if (i < 4) exp_q.push_back(u);
      #1 chk("pd_drop", pd_drop, (i == 4) ? 1 : 0);
      step();
    end
    pd_we = 0; busy = 0;
    drain("drain_overflow", 8);

    // Flush with concurrent push and resolve: only the resolve is written.
    busy = 1; pd_we = 1;
    for (int i = 0; i < 3; i++) begin
      set_pd(mk(64'h9000 + i, 3'd0, BR_COND, 64'h9100 + i));
      step();
    end
    busy = 0; flush = 1;
    set_pd(mk(64'h9999, 3'd5, BR_COND, 64'h9998));
    set_rs(mk(64'hA000, 3'd4, BR_RET, 64'hA0A0)); rs_valid = 1;
    exp_q.push_back(mk(64'hA000, 3'd4, BR_RET, 64'hA0A0));
    #1 chk("rs_ready_flush", rs_ready, 1);
    chk("drop_flush", pd_drop, 0);
    step(); flush = 0; pd_we = 0; rs_valid = 0;
    drain("drain_flush", 4);
    repeat (6) step();
    u = mk(64'hB000, 3'd6, BR_CALL, 64'hB0B0); set_pd(u); pd_we = 1;
    exp_q.push_back(u);
    step(); pd_we = 0;
    drain("drain_post_flush", 4);

    // Reset during an active write; buffered entries must be lost.
    busy = 1; pd_we = 1;
    set_pd(mk(64'hC000, 3'd1, BR_JUMP, 64'hC0C0)); step();
    set_pd(mk(64'hC100, 3'd2, BR_JUMP, 64'hC1C1)); step();
    pd_we = 0; busy = 0;
    set_rs(mk(64'hD000, 3'd3, BR_COND, 64'hD0D0)); rs_valid = 1;
    step(); rs_valid = 0;
    chk("we_pre_reset", btb_we, 1);
    rst_n = 1'b0;
    #1 chk("we_async_reset", btb_we, 0);
    step(); step();
    rst_n = 1'b1;
    repeat (8) step();
    u = mk(64'hE000, 3'd0, BR_RET, 64'hE0E0); set_rs(u); rs_valid = 1;
    exp_q.push_back(u);
    step(); rs_valid = 0;
    drain("drain_post_reset", 4);
    repeat (3) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
